bmem_arbiter: RTL and testbench



---
 rtl/bmem_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_bmem_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bmem_arbiter.sv
// bmem_arbiter
// Shares the single burst-memory (bmem) port between the icache line-fill path
// and the dcache line-fill/writeback path. Each granted line request becomes a
// BEATS-beat, 64-bit burst; read beats are reassembled into a full line and
// handed to the owning requester together with a one-cycle response pulse.
// Only one bmem transaction is in flight at a time.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   ic_addr/ic_read           icache line read request (level, held until ic_resp)
//   ic_rdata/ic_resp          icache fill line, one-cycle valid pulse
//   dc_addr/dc_read/dc_write  dcache line request (level, held until dc_resp)
//   dc_wdata                  dcache writeback line, captured at grant
//   dc_rdata/dc_resp          dcache fill line, one-cycle done/valid pulse
//   bmem_addr/read/write      burst command and write-beat strobe
//   bmem_wdata                current write beat
//   bmem_ready                memory accepts the command/beat this cycle
//   bmem_raddr/rdata/rvalid   returning read beat with its address tag
//
// state      | meaning
// -----------+---------------------------------------------------------
// S_IDLE     | no transaction; round-robin arbitration, latch on grant
// S_RD_CMD   | bmem_read asserted until bmem_ready accepts it
// S_RD_WAIT  | collecting tagged read beats into the line buffer
// S_WR_BURST | streaming writeback beats, advancing on bmem_ready
// S_RESP     | one-cycle response pulse to the owner
module bmem_arbiter #(
  parameter int BEATS      = 4,
  parameter int ADDR_ALIGN = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           ic_addr,
  input  logic                  ic_read,
  output logic [64*BEATS-1:0]   ic_rdata,
  output logic                  ic_resp,
  input  logic [31:0]           dc_addr,
  input  logic                  dc_read,
  input  logic                  dc_write,
  input  logic [64*BEATS-1:0]   dc_wdata,
  output logic [64*BEATS-1:0]   dc_rdata,
  output logic                  dc_resp,
  output logic [31:0]           bmem_addr,
  output logic                  bmem_read,
  output logic                  bmem_write,
  output logic [63:0]           bmem_wdata,
  input  logic                  bmem_ready,
  input  logic [31:0]           bmem_raddr,
  input  logic [63:0]           bmem_rdata,
  input  logic                  bmem_rvalid
);

  localparam int LW = 64 * BEATS;
  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [31:0] ALIGN_MASK = ~((32'd1 << ADDR_ALIGN) - 32'd1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_CMD,
    S_RD_WAIT,
    S_WR_BURST,
    S_RESP
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic            r_owner_dc;   // 0: icache owns the transaction, 1: dcache
  logic            r_rr_dc;      // 1: dcache wins the next contended grant
  logic [31:0]     r_addr;
  logic [LW-1:0]   r_wline;
  logic [LW-1:0]   r_line;
  logic [BW-1:0]   r_beat;
  logic [LW-1:0]   r_ic_rdata;
  logic [LW-1:0]   r_dc_rdata;

  logic            w_ic_req;
  logic            w_dc_req;
  logic            w_grant;
  logic            w_grant_dc;
  logic            w_beat_hit;
  logic            w_beat_last;
  logic [LW-1:0]   w_line_nxt;

  always_comb begin
    w_ic_req    = ic_read;
    w_dc_req    = dc_read | dc_write;
    w_grant     = w_ic_req | w_dc_req;
    w_grant_dc  = w_dc_req & (~w_ic_req | r_rr_dc);
    // Beats tagged with another address belong to someone else; drop them.
    w_beat_hit  = bmem_rvalid & (bmem_raddr == r_addr);
    w_beat_last = (r_beat == LAST_BEAT);
  end

  always_comb begin
    w_line_nxt = r_line;
    if (r_state == S_RD_WAIT && w_beat_hit) begin
      w_line_nxt[64*r_beat +: 64] = bmem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    bmem_read   = 1'b0;
    bmem_write  = 1'b0;
    bmem_wdata  = '0;
    bmem_addr   = r_addr;
    ic_resp     = 1'b0;
    dc_resp     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_grant) begin
          // A simultaneous dc_read/dc_write resolves to the writeback.
          w_state_nxt = (w_grant_dc && dc_write) ? S_WR_BURST : S_RD_CMD;
        end
      end
      S_RD_CMD: begin
        bmem_read = 1'b1;
        if (bmem_ready) begin
          w_state_nxt = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (w_beat_hit && w_beat_last) begin
          w_state_nxt = S_RESP;
        end
      end
      S_WR_BURST: begin
        bmem_write = 1'b1;
        bmem_wdata = r_wline[64*r_beat +: 64];
        if (bmem_ready && w_beat_last) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        ic_resp     = ~r_owner_dc;
        dc_resp     = r_owner_dc;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner_dc <= 1'b0;
      r_rr_dc    <= 1'b0;
      r_addr     <= '0;
      r_wline    <= '0;
      r_line     <= '0;
      r_beat     <= '0;
      r_ic_rdata <= '0;
      r_dc_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_owner_dc <= w_grant_dc;
            r_rr_dc    <= ~w_grant_dc;
            r_addr     <= (w_grant_dc ? dc_addr : ic_addr) & ALIGN_MASK;
            r_beat     <= '0;
            if (w_grant_dc) begin
              r_wline <= dc_wdata;
            end
          end
        end
        S_RD_WAIT: begin
          if (w_beat_hit) begin
            r_line <= w_line_nxt;
            r_beat <= r_beat + BW'(1);
            // The returned line is published to its owner only once complete,
            // so the other requester's last fill stays intact.
            if (w_beat_last) begin
              if (r_owner_dc) begin
                r_dc_rdata <= w_line_nxt;
              end else begin
                r_ic_rdata <= w_line_nxt;
              end
            end
          end
        end
        S_WR_BURST: begin
          if (bmem_ready) begin
            r_beat <= r_beat + BW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign ic_rdata = r_ic_rdata;
  assign dc_rdata = r_dc_rdata;

endmodule

// File: tb/tb_bmem_arbiter.sv
module tb_bmem_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  ic_addr;
  logic         ic_read;
  logic [255:0] ic_rdata;
  logic         ic_resp;
  logic [31:0]  dc_addr;
  logic         dc_read;
  logic         dc_write;
  logic [255:0] dc_wdata;
  logic [255:0] dc_rdata;
  logic         dc_resp;
  logic [31:0]  bmem_addr;
  logic         bmem_read;
  logic         bmem_write;
  logic [63:0]  bmem_wdata;
  logic         bmem_ready;
  logic [31:0]  bmem_raddr;
  logic [63:0]  bmem_rdata;
  logic         bmem_rvalid;

  always #5 clk = ~clk;

  bmem_arbiter #(.BEATS(4), .ADDR_ALIGN(5)) dut (
    .clk(clk), .rst(rst),
    .ic_addr(ic_addr), .ic_read(ic_read), .ic_rdata(ic_rdata), .ic_resp(ic_resp),
    .dc_addr(dc_addr), .dc_read(dc_read), .dc_write(dc_write), .dc_wdata(dc_wdata),
    .dc_rdata(dc_rdata), .dc_resp(dc_resp),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
    .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
  );

  localparam logic [63:0] B0 = 64'h1111_1111_1111_1111;
  localparam logic [63:0] B1 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] B2 = 64'h3333_3333_3333_3333;
  localparam logic [63:0] B3 = 64'h4444_4444_4444_4444;
  localparam logic [63:0] BAD = 64'hBAD0_BAD0_BAD0_BAD0;
  localparam logic [255:0] LINE_R = {B3, B2, B1, B0};
  localparam logic [63:0] W0 = 64'hA000_0000_0000_00A0;
  localparam logic [63:0] W1 = 64'hA111_0000_0000_01A1;
  localparam logic [63:0] W2 = 64'hA222_0000_0000_02A2;
  localparam logic [63:0] W3 = 64'hA333_0000_0000_03A3;
  localparam logic [255:0] LINE_W = {W3, W2, W1, W0};
  localparam logic [63:0] V0 = 64'h5000_0000_CAFE_0000;
  localparam logic [63:0] V1 = 64'h5111_0000_CAFE_0001;
  localparam logic [63:0] V2 = 64'h5222_0000_CAFE_0002;
  localparam logic [63:0] V3 = 64'h5333_0000_CAFE_0003;
  localparam logic [255:0] LINE_V = {V3, V2, V1, V0};
  localparam logic [255:0] LINE_G = {4{64'hFFFF_EEEE_DDDD_CCCC}};
  localparam logic [31:0] A = 32'h0000_1000;
  localparam logic [31:0] D = 32'h8000_0040;
  localparam logic [31:0] X = 32'hDEAD_0000;

  typedef struct {
    logic        rst;
    logic        ic_rd;
    logic        dc_wr;
    logic        rdy;
    logic        rv;
    logic [31:0] raddr;
    logic [63:0] rdata;
    logic [1:0]  wsel;
    logic        e_icr;
    logic        e_dcr;
    logic        e_brd;
    logic        e_bwr;
    logic [31:0] e_addr;
    logic [63:0] e_wd;
    logic        e_icl;
    logic        e_dcl;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic add(input logic r, input logic icr, input logic dcw, input logic rdy,
                     input logic rv, input logic [31:0] ra, input logic [63:0] rd,
                     input logic [1:0] ws, input logic eic, input logic edc,
                     input logic erd, input logic ewr, input logic [31:0] ea,
                     input logic [63:0] ewd, input logic eicl, input logic edcl);
    vec_t v;
    v.rst = r; v.ic_rd = icr; v.dc_wr = dcw; v.rdy = rdy; v.rv = rv;
    v.raddr = ra; v.rdata = rd; v.wsel = ws;
    v.e_icr = eic; v.e_dcr = edc; v.e_brd = erd; v.e_bwr = ewr;
    v.e_addr = ea; v.e_wd = ewd; v.e_icl = eicl; v.e_dcl = edcl;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [255:0] act,
                     input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  function automatic logic [63:0] mbeat(input logic [31:0] addr, input int k);
    return {addr ^ 32'h5A5A_0000, 32'(k) * 32'h0101_0101 + 32'hC0DE_0000};
  endfunction

  function automatic logic [255:0] mline(input logic [31:0] addr);
    logic [255:0] l;
    for (int k = 0; k < 4; k++) l[64*k +: 64] = mbeat(addr, k);
    return l;
  endfunction

  // Reactive memory with immediate command acceptance; serves ic and/or dc
  // reads and checks service order, per-requester data and pulse counts.
  task automatic run_reqs(input bit rq_ic, input bit rq_dc, input bit exp_dc_first,
                          input string tag);
    logic [31:0] a_i, a_d, paddr;
    int needed, served, ic_cnt, dc_cnt, rd_cnt, k;
    bit first_set, first_dc, pend, drop_ic, drop_dc;
    a_i = 32'h0000_2010;
    a_d = 32'h4000_007C;
    needed = int'(rq_ic) + int'(rq_dc);
    served = 0; ic_cnt = 0; dc_cnt = 0; rd_cnt = 0; k = 0; paddr = '0;
    first_set = 0; first_dc = 0; pend = 0; drop_ic = 0; drop_dc = 0;
    @(negedge clk);
    ic_addr = a_i; dc_addr = a_d; dc_write = 1'b0;
    ic_read = rq_ic; dc_read = rq_dc;
    bmem_ready = 1'b0; bmem_rvalid = 1'b0; bmem_raddr = '0; bmem_rdata = '0;
    for (int cyc = 0; cyc < 200 && served < needed; cyc++) begin
      @(negedge clk);
      if (drop_ic) ic_read = 1'b0;
      if (drop_dc) dc_read = 1'b0;
      bmem_ready = bmem_read;
      if (pend) begin
        bmem_rvalid = 1'b1; bmem_raddr = paddr; bmem_rdata = mbeat(paddr, k);
        k++;
        if (k == 4) pend = 0;
      end else begin
        bmem_rvalid = 1'b0;
      end
      if (bmem_read) begin
        rd_cnt++; pend = 1; paddr = bmem_addr; k = 0;
      end
      if (ic_resp) begin
        ic_cnt++; served++; drop_ic = 1;
        if (!first_set) begin first_set = 1; first_dc = 0; end
        chk({tag, " ic_rdata"}, served, ic_rdata, mline(32'h0000_2000));
      end
      if (dc_resp) begin
        dc_cnt++; served++; drop_dc = 1;
        if (!first_set) begin first_set = 1; first_dc = 1; end
        chk({tag, " dc_rdata"}, served, dc_rdata, mline(32'h4000_0060));
      end
    end
    if (served < needed) begin
      n_vec++; n_bad++;
      $display("FAIL %s timeout: served %0d of %0d", tag, served, needed);
    end
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      ic_read = 1'b0; dc_read = 1'b0; bmem_ready = 1'b0; bmem_rvalid = 1'b0;
      if (ic_resp) ic_cnt++;
      if (dc_resp) dc_cnt++;
      if (bmem_read) rd_cnt++;
    end
    chk({tag, " ic_resp count"}, 0, 256'(ic_cnt), 256'(int'(rq_ic)));
    chk({tag, " dc_resp count"}, 0, 256'(dc_cnt), 256'(int'(rq_dc)));
    chk({tag, " bmem_read pulses"}, 0, 256'(rd_cnt), 256'(needed));
    if (rq_ic && rq_dc) chk({tag, " dc served first"}, 0, 256'(first_dc), 256'(exp_dc_first));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ic_addr = 32'h0000_1004; ic_read = 1'b0;
    dc_addr = 32'h8000_0044; dc_read = 1'b0; dc_write = 1'b0; dc_wdata = LINE_W;
    bmem_ready = 1'b0; bmem_raddr = '0; bmem_rdata = '0; bmem_rvalid = 1'b0;
    @(posedge clk);

    //   rst ic dcw rdy rv raddr rdata ws | icr dcr brd bwr addr wdata icl dcl
    add(1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0,  0, 0);
    add(0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0,  0, 0);
    add(0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0, A, 0,  0, 0);
    add(0, 1, 0, 1, 0, 0, 0,   0, 0, 0, 1, 0, A, 0,  0, 0);
    add(0, 1, 0, 0, 1, A, B0,  0, 0, 0, 0, 0, A, 0,  0, 0);
    add(0, 1, 0, 0, 1, X, BAD, 0, 0, 0, 0, 0, A, 0,  0, 0);
    add(0, 1, 0, 0, 1, A, B1,  0, 0, 0, 0, 0, A, 0,  0, 0);
    add(0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, A, 0,  0, 0);
    add(0, 1, 0, 0, 1, A, B2,  0, 0, 0, 0, 0, A, 0,  0, 0);
    add(0, 1, 0, 0, 1, A, B3,  0, 0, 0, 0, 0, A, 0,  0, 0);
    add(0, 1, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, A, 0,  1, 0);
    add(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, A, 0,  1, 0);
    add(0, 0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, A, 0,  1, 0);
    add(0, 0, 1, 1, 0, 0, 0,   2, 0, 0, 0, 1, D, W0, 1, 0);
    add(0, 0, 1, 1, 0, 0, 0,   2, 0, 0, 0, 1, D, W1, 1, 0);
    add(0, 0, 1, 1, 0, 0, 0,   2, 0, 0, 0, 1, D, W2, 1, 0);
    add(0, 0, 1, 1, 0, 0, 0,   2, 0, 0, 0, 1, D, W3, 1, 0);
    add(0, 0, 1, 0, 0, 0, 0,   2, 0, 1, 0, 0, D, 0,  1, 0);
    add(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, D, 0,  1, 0);
    add(0, 0, 1, 0, 0, 0, 0,   1, 0, 0, 0, 0, D, 0,  1, 0);
    add(0, 0, 1, 1, 0, 0, 0,   2, 0, 0, 0, 1, D, V0, 1, 0);
    add(0, 0, 1, 0, 0, 0, 0,   2, 0, 0, 0, 1, D, V1, 1, 0);
    add(0, 0, 1, 0, 0, 0, 0,   2, 0, 0, 0, 1, D, V1, 1, 0);
    add(0, 0, 1, 1, 0, 0, 0,   2, 0, 0, 0, 1, D, V1, 1, 0);
    add(0, 0, 1, 1, 0, 0, 0,   2, 0, 0, 0, 1, D, V2, 1, 0);
    add(0, 0, 1, 0, 0, 0, 0,   2, 0, 0, 0, 1, D, V3, 1, 0);
    add(0, 0, 1, 1, 0, 0, 0,   2, 0, 0, 0, 1, D, V3, 1, 0);
    add(0, 0, 1, 0, 0, 0, 0,   2, 0, 1, 0, 0, D, 0,  1, 0);
    add(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, D, 0,  1, 0);
    add(0, 0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, D, 0,  1, 0);
    add(0, 0, 1, 1, 0, 0, 0,   2, 0, 0, 0, 1, D, W0, 1, 0);
    add(0, 0, 1, 1, 0, 0, 0,   2, 0, 0, 0, 1, D, W1, 1, 0);
    add(1, 0, 1, 1, 0, 0, 0,   2, 0, 0, 0, 1, D, W2, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0,  0, 0);
    add(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0,  0, 0);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      rst = vq[i].rst; ic_read = vq[i].ic_rd; dc_read = 1'b0; dc_write = vq[i].dc_wr;
      bmem_ready = vq[i].rdy; bmem_rvalid = vq[i].rv;
      bmem_raddr = vq[i].raddr; bmem_rdata = vq[i].rdata;
      case (vq[i].wsel)
        2'd0:    dc_wdata = LINE_W;
        2'd1:    dc_wdata = LINE_V;
        default: dc_wdata = LINE_G;
      endcase
      #1;
      chk("ic_resp",    i, 256'(ic_resp),    256'(vq[i].e_icr));
      chk("dc_resp",    i, 256'(dc_resp),    256'(vq[i].e_dcr));
      chk("bmem_read",  i, 256'(bmem_read),  256'(vq[i].e_brd));
      chk("bmem_write", i, 256'(bmem_write), 256'(vq[i].e_bwr));
      chk("bmem_addr",  i, 256'(bmem_addr),  256'(vq[i].e_addr));
      chk("bmem_wdata", i, 256'(bmem_wdata), 256'(vq[i].e_wd));
      chk("ic_rdata",   i, ic_rdata, vq[i].e_icl ? LINE_R : 256'd0);
      chk("dc_rdata",   i, dc_rdata, 256'd0);
    end

    run_reqs(1'b1, 1'b1, 1'b0, "rr_first");
    run_reqs(1'b1, 1'b0, 1'b0, "solo_ic");
    run_reqs(1'b1, 1'b1, 1'b1, "rr_alt");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
